// File: rtl/jal_issue_ctrl.sv
// In-order issue queue and jalr serialisation for the jal/jalr execution unit.
// Optional macro JAL_ISSUE_BYPASS_EN lets an op issue straight from dispatch when the queue is empty.
module jal_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RB    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dsp_vaild,
  output logic              dsp_ready,
  input  logic              dsp_is_jalr,
  input  logic [4+RB:0]     dsp_rd0,
  input  logic [4+RB:0]     dsp_rs1,
  input  logic [63:0]       dsp_pc,
  input  logic              dsp_is_rvc,
  output logic [4+RB:0]     rs1_idx,
  input  logic              rs1_ready,
  input  logic [63:0]       rs1_data,
  output logic              jal_exeparam_vaild,
  output logic [RB+135:0]   jal_exeparam,
  input  logic              jalr_resolved,
  input  logic              flush
);

  localparam int unsigned TW = 5 + RB;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  typedef enum logic {StIdle, StJalrWait} state_e;

  state_e state_q, state_d;
  logic   fsm_idle;

  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]  wr_idx, rd_idx;
  logic [DEPTH-1:0] ent_vld_q, ent_jalr_q, ent_rvc_q;
  logic [TW-1:0]  ent_rd_q  [DEPTH];
  logic [TW-1:0]  ent_rs1_q [DEPTH];
  logic [63:0]    ent_pc_q  [DEPTH];

  logic empty, full, enq, deq, head_go, byp_go, iss_go;
  logic iss_jalr, iss_rvc;
  logic [TW-1:0] iss_rd;
  logic [63:0]   iss_pc;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign dsp_ready = !full && !flush;
  assign head_go   = !empty && ent_vld_q[rd_idx] && !flush &&
                     (!ent_jalr_q[rd_idx] || (rs1_ready && fsm_idle));

`ifdef JAL_ISSUE_BYPASS_EN
  assign byp_go  = empty && dsp_vaild && !flush && (!dsp_is_jalr || (rs1_ready && fsm_idle));
  assign rs1_idx = empty ? dsp_rs1 : ent_rs1_q[rd_idx];
`else
  assign byp_go  = 1'b0;
  assign rs1_idx = empty ? '0 : ent_rs1_q[rd_idx];
`endif

  assign iss_go   = head_go || byp_go;
  assign deq      = head_go;
  assign enq      = dsp_vaild && dsp_ready && !byp_go;
  assign iss_jalr = byp_go ? dsp_is_jalr : ent_jalr_q[rd_idx];
  assign iss_rvc  = byp_go ? dsp_is_rvc  : ent_rvc_q[rd_idx];
  assign iss_rd   = byp_go ? dsp_rd0     : ent_rd_q[rd_idx];
  assign iss_pc   = byp_go ? dsp_pc      : ent_pc_q[rd_idx];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ent_vld_q <= '0;
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ent_vld_q <= '0;
    end else begin
      if (enq) begin
        wr_ptr_q          <= wr_ptr_q + PtrOne;
        ent_vld_q[wr_idx] <= 1'b1;
      end
      if (deq) begin
        rd_ptr_q          <= rd_ptr_q + PtrOne;
        ent_vld_q[rd_idx] <= 1'b0;
      end
    end
  end

  // Payload needs no reset: ent_vld_q and the pointers gate every read.
  always_ff @(posedge CLK) begin
    if (enq) begin
      ent_jalr_q[wr_idx] <= dsp_is_jalr;
      ent_rvc_q[wr_idx]  <= dsp_is_rvc;
      ent_rd_q[wr_idx]   <= dsp_rd0;
      ent_rs1_q[wr_idx]  <= dsp_rs1;
      ent_pc_q[wr_idx]   <= dsp_pc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (iss_go && iss_jalr) state_d = StJalrWait;
        StJalrWait: if (jalr_resolved)      state_d = StIdle;
        default:                            state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    fsm_idle = (state_q == StIdle);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      jal_exeparam_vaild <= 1'b0;
      jal_exeparam       <= '0;
    end else if (flush) begin
      jal_exeparam_vaild <= 1'b0;
    end else begin
      jal_exeparam_vaild <= iss_go;
      if (iss_go) begin
        jal_exeparam <= {!iss_jalr, iss_jalr, iss_rd, (iss_jalr ? rs1_data : 64'd0),
                         iss_pc, iss_rvc};
      end
    end
  end

endmodule
